// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and constants for the stream source
// Holds the FSM state enum, LFSR taps (used under STREAM_SRC_LFSR_EN) and default widths.
package stream_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 8;
  localparam int GAP_W_DEF  = 4;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } src_state_e;

endpackage

// File: rtl/stream_lfsr.sv
// rtl/stream_lfsr.sv - Fibonacci LFSR data generator for the stream source
// Instantiated by stream_src only when STREAM_SRC_LFSR_EN is defined; W must be 8 or 16.
module stream_lfsr
  import stream_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] TAPS = (W == 16) ? W'(LFSR_TAPS_16) : W'(LFSR_TAPS_8);

  generate
    if (W != 8 && W != 16) begin : g_bad_width
      $error("stream_lfsr: unsupported width %0d", W);
    end
  endgenerate

  // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= (seed == '0) ? W'(1) : seed;
    end else if (step) begin
      value <= {value[W-2:0], ^(value & TAPS)};
    end
  end

endmodule

// File: rtl/stream_src.sv
// rtl/stream_src.sv - valid/ready burst source with backpressure and inter-beat gaps
// Define STREAM_SRC_LFSR_EN to generate LFSR data instead of an incrementing count.
module stream_src
  import stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int GAP_W  = GAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  input  logic [LEN_W-1:0]  beats,
  input  logic [GAP_W-1:0]  gap,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  beat_cnt
);

  src_state_e       state_q, state_n;
  logic             valid_n, busy_n, done_n;
  logic [LEN_W-1:0] cnt_n, beats_q, beats_n;
  logic [GAP_W-1:0] gap_q, gap_n, gap_cnt_q, gap_cnt_n;
  logic             load, transfer, last_beat;

  assign load      = (state_q == IDLE) && start;
  assign transfer  = (state_q == SEND) && out_ready;
  assign last_beat = ((beat_cnt + LEN_W'(1)) == beats_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      beat_cnt  <= '0;
      beats_q   <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_n;
      out_valid <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
      beat_cnt  <= cnt_n;
      beats_q   <= beats_n;
      gap_q     <= gap_n;
      gap_cnt_q <= gap_cnt_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    valid_n   = out_valid;
    busy_n    = busy;
    done_n    = 1'b0;
    cnt_n     = beat_cnt;
    beats_n   = beats_q;
    gap_n     = gap_q;
    gap_cnt_n = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          beats_n = beats;
          gap_n   = gap;
          cnt_n   = '0;
          if (beats == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = SEND;
            valid_n = 1'b1;
            busy_n  = 1'b1;
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          cnt_n = beat_cnt + LEN_W'(1);
          if (last_beat) begin
            state_n = DONE;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else if (gap_q != '0) begin
            state_n   = GAP;
            valid_n   = 1'b0;
            gap_cnt_n = gap_q;
          end
        end
      end
      GAP: begin
        // The counter reaching 1 marks the last idle cycle of the gap.
        gap_cnt_n = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) begin
          state_n = SEND;
          valid_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef STREAM_SRC_LFSR_EN
  logic [DATA_W-1:0] lfsr_value;

  stream_lfsr #(.W(DATA_W)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .seed  (seed),
    .step  (transfer),
    .value (lfsr_value)
  );

  assign out_data = lfsr_value;
`else
  // Advancing on every transfer keeps the value stable across stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= seed;
    end else if (transfer) begin
      out_data <= out_data + DATA_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_stream_src.sv
// tb/tb_stream_src.sv - directed bench for stream_src with a per-cycle reference model
module tb_stream_src;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] seed = '0;
  logic [7:0] beats = '0;
  logic [3:0] gap = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic [7:0] beat_cnt;

  stream_src #(.DATA_W(8), .LEN_W(8), .GAP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed      (seed),
    .beats     (beats),
    .gap       (gap),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: burst bookkeeping in terms of beats accepted and idle cycles owed.
  bit         chk_en = 1'b0;
  bit         m_active = 1'b0, m_valid = 1'b0, m_done = 1'b0;
  logic [7:0] m_data = '0, m_cnt = '0, m_beats = '0;
  int         m_gap = 0, m_wait = 0;

  logic [7:0] acc_q[$];
  logic [7:0] stall_q[$];
  int         acc_cyc_q[$];
  int         done_cnt = 0, done_cyc = -1, valid_cycles = 0, start_cyc = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      bit nd;
      check("out_valid", out_valid, m_valid);
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("beat_cnt", beat_cnt, m_cnt);
      if (m_valid) check("out_data", out_data, m_data);

      if (out_valid) valid_cycles++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && !out_ready) stall_q.push_back(out_data);
      if (out_valid && out_ready && !rst) begin
        acc_q.push_back(out_data);
        acc_cyc_q.push_back(cyc + 1);
      end

      nd = 1'b0;
      if (rst) begin
        m_active = 1'b0;
        m_valid  = 1'b0;
        m_cnt    = '0;
      end else if (!m_active && !m_done) begin
        if (start) begin
          start_cyc = cyc + 1;
          m_cnt   = '0;
          m_beats = beats;
          m_gap   = gap;
          if (beats == 0) begin
            nd = 1'b1;
          end else begin
            m_active = 1'b1;
            m_valid  = 1'b1;
            m_data   = seed;
          end
        end
      end else if (m_active) begin
        if (m_valid) begin
          if (out_ready) begin
            m_cnt++;
            m_data++;
            if (m_cnt == m_beats) begin
              m_active = 1'b0;
              m_valid  = 1'b0;
              nd = 1'b1;
            end else if (m_gap != 0) begin
              m_valid = 1'b0;
              m_wait  = m_gap;
            end
          end
        end else begin
          m_wait--;
          if (m_wait == 0) m_valid = 1'b1;
        end
      end
      m_done = nd;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_q.delete();
    stall_q.delete();
    acc_cyc_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    valid_cycles = 0;
    start_cyc = -1;
  endtask

  task automatic pulse_start(input logic [7:0] s, input logic [7:0] b, input logic [3:0] g);
    seed = s;
    beats = b;
    gap = g;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick(1);
      n++;
    end
    check("done_within_budget", (done_cnt != 0), 1);
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(1);
    chk_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);

    // Reset held for two idle cycles
    rst = 1'b1;
    tick(2);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", beat_cnt, 0);
    rst = 1'b0;
    tick(1);

    // Basic burst, back-to-back
    clear_logs();
    out_ready = 1'b1;
    pulse_start(8'h55, 8'd4, 4'd0);
    wait_done(20);
    check("basic_n", acc_q.size(), 4);
    check("basic_b0", acc_q[0], 8'h55);
    check("basic_b1", acc_q[1], 8'h56);
    check("basic_b2", acc_q[2], 8'h57);
    check("basic_b3", acc_q[3], 8'h58);
    check("basic_cnt", beat_cnt, 4);
    check("basic_done_pulses", done_cnt, 1);
    check("basic_first_beat", acc_cyc_q[0], start_cyc + 1);
    check("basic_span", acc_cyc_q[3] - acc_cyc_q[0], 3);
    check("basic_done_time", done_cyc, acc_cyc_q[3]);

    // Backpressure on the second beat for three cycles
    clear_logs();
    out_ready = 1'b1;
    pulse_start(8'h55, 8'd4, 4'd0);
    tick(1);
    out_ready = 1'b0;
    tick(3);
    out_ready = 1'b1;
    wait_done(20);
    check("bp_stalls", stall_q.size(), 3);
    for (int i = 0; i < 3; i++) check("bp_hold", stall_q[i], 8'h56);
    check("bp_n", acc_q.size(), 4);
    for (int i = 0; i < 4; i++) check("bp_beat", acc_q[i], 8'h55 + i);
    check("bp_cnt", beat_cnt, 4);

    // Inter-beat gap of two cycles
    clear_logs();
    pulse_start(8'h10, 8'd3, 4'd2);
    wait_done(30);
    check("gap_n", acc_q.size(), 3);
    check("gap_d01", acc_cyc_q[1] - acc_cyc_q[0], 3);
    check("gap_d12", acc_cyc_q[2] - acc_cyc_q[1], 3);
    check("gap_valid_cycles", valid_cycles, 3);
    check("gap_done_time", done_cyc, acc_cyc_q[2]);
    check("gap_b2", acc_q[2], 8'h12);

    // Data wrap
    clear_logs();
    pulse_start(8'hFE, 8'd3, 4'd0);
    wait_done(20);
    check("wrap_n", acc_q.size(), 3);
    check("wrap_b0", acc_q[0], 8'hFE);
    check("wrap_b1", acc_q[1], 8'hFF);
    check("wrap_b2", acc_q[2], 8'h00);

    // Zero-length burst
    clear_logs();
    pulse_start(8'h40, 8'd0, 4'd0);
    wait_done(5);
    check("zero_valid_cycles", valid_cycles, 0);
    check("zero_done_pulses", done_cnt, 1);
    check("zero_done_time", done_cyc, start_cyc);
    check("zero_cnt", beat_cnt, 0);

    // Reset while the second beat is presented
    clear_logs();
    pulse_start(8'h20, 8'd5, 4'd0);
    tick(1);
    rst = 1'b1;
    tick(1);
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_cnt", beat_cnt, 0);
    rst = 1'b0;
    tick(8);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_accepted", acc_q.size(), 1);

    // Start asserted during SEND is ignored
    clear_logs();
    pulse_start(8'h30, 8'd4, 4'd1);
    pulse_start(8'h99, 8'd9, 4'd0);
    wait_done(30);
    check("busy_start_n", acc_q.size(), 4);
    for (int i = 0; i < 4; i++) check("busy_start_beat", acc_q[i], 8'h30 + i);
    check("busy_start_cnt", beat_cnt, 4);
    check("busy_start_done", done_cnt, 1);

    tick(3);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
